wb_arbiter_rr: RTL

Round-robin Wishbone arbiter that lets N bus masters share one peripheral Wishbone port. Typical use: the SoC CPU bridge and a second master (USB-side control engine or DMA) share the `wb_m_*` peripheral bus that feeds misc, GPS UART and I2C. The block registers the grant, forwards one transaction at a time, returns `ack`/`rdata` to the granted master, and aborts stalled transactions with an error pulse.

---
 rtl/wb_arbiter_rr_pkg.sv | 13 +
 rtl/arb_rr_pick.sv | 32 +++
 rtl/wb_arbiter_rr.sv | 129 ++++++++++++
 3 files changed

// File: rtl/wb_arbiter_rr_pkg.sv
// Shared types for the round-robin Wishbone arbiter: FSM state and timeout counter sizing.
package wb_arbiter_rr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: lowest offset from ptr (mod N) among set req bits wins.
// Zero latency; gnt is all-zero and any is low when nothing is requesting.
module arb_rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    any  = |req;
    for (int off = N - 1; off >= 0; off--) begin
      cand = PW'((int'(ptr) + off) % N);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter sharing one Wishbone slave between N masters, one transaction at a time.
// Grant registered one cycle after m_cyc; ack/rdata pass straight through; stalls abort after TIMEOUT cycles.
module wb_arbiter_rr
  import wb_arbiter_rr_pkg::*;
#(
  parameter int N       = 2,
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*AW-1:0]   m_addr,
  input  logic [N*DW-1:0]   m_wdata,
  input  logic [N*DW/8-1:0] m_wmsk,
  input  logic [N-1:0]      m_we,
  input  logic [N-1:0]      m_cyc,
  output logic [N-1:0]      m_ack,
  output logic [N-1:0]      m_err,
  output logic [DW-1:0]     m_rdata,
  output logic [AW-1:0]     s_addr,
  output logic [DW-1:0]     s_wdata,
  output logic [DW/8-1:0]   s_wmsk,
  output logic              s_we,
  output logic              s_cyc,
  input  logic              s_ack,
  input  logic [DW-1:0]     s_rdata,
  output logic [N-1:0]      gnt,
  output logic              busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = DW / 8;
  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t        state;
  logic [PW-1:0] gidx;
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic [N-1:0]  pick_gnt;
  logic [PW-1:0] pick_idx;
  logic          pick_any;

  logic [AW-1:0] addr_a  [N];
  logic [DW-1:0] wdata_a [N];
  logic [MW-1:0] wmsk_a  [N];

  logic [PW-1:0] sel;
  logic [PW-1:0] next_ptr;
  logic          xfer;
  logic          cyc_g;
  logic          done_ack;
  logic          done_abort;
  logic          timed_out;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign addr_a[i]  = m_addr[i*AW +: AW];
    assign wdata_a[i] = m_wdata[i*DW +: DW];
    assign wmsk_a[i]  = m_wmsk[i*MW +: MW];
  end

  arb_rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req (m_cyc),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign xfer  = (state == XFER);
  assign sel   = xfer ? gidx : '0;
  assign cyc_g = m_cyc[gidx];

  assign s_addr  = addr_a[sel];
  assign s_wdata = wdata_a[sel];
  assign s_wmsk  = wmsk_a[sel];
  assign s_we    = m_we[sel];
  assign s_cyc   = xfer;
  assign busy    = xfer;
  assign m_rdata = s_rdata;

  // cnt holds the number of completed XFER cycles, so CNT_LAST marks the TIMEOUT-th one.
  assign done_ack   = xfer && cyc_g && s_ack;
  assign done_abort = xfer && !cyc_g;
  assign timed_out  = (TIMEOUT != 0) && xfer && cyc_g && !s_ack && (cnt == CNT_LAST);

  assign m_ack = (done_ack && !rst) ? gnt : '0;
  assign m_err = (timed_out && !rst) ? gnt : '0;

  assign next_ptr = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      gidx  <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state <= XFER;
            gnt   <= pick_gnt;
            gidx  <= pick_idx;
            cnt   <= '0;
          end
        end
        XFER: begin
          if (done_ack || done_abort || timed_out) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= next_ptr;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
